// File: rtl/mult_pool_collector.sv
// Pool of Nmult MAC lanes behind the controller's claim/operand/result interface.
// Each lane sums one output pixel's taps; the lowest-index finished lane is returned first.

module mpc_lane #(
  parameter int W    = 16,
  parameter int ACCW = 40,
  parameter int TAGW = 10
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_flush,
  input  logic                   i_claim,
  input  logic                   i_beat,
  input  logic signed [W-1:0]    i_a,
  input  logic signed [W-1:0]    i_b,
  input  logic                   i_last,
  input  logic [TAGW-1:0]        i_tag,
  input  logic                   i_release,
  output logic                   o_busy,
  output logic                   o_acc,
  output logic                   o_drain,
  output logic                   o_ready,
  output logic [ACCW-1:0]        o_sum,
  output logic [TAGW-1:0]        o_tag
);
  typedef enum logic [1:0] {FREE, ACC, DRAIN, DONE} lane_st_t;

  lane_st_t               r_st;
  logic signed [2*W-1:0]  r_prod;
  logic                   r_pv;
  logic [ACCW-1:0]        r_acc;
  logic [TAGW-1:0]        r_tag;
  logic signed [ACCW-1:0] w_prod_ext;

  assign w_prod_ext = ACCW'(r_prod);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_st   <= FREE;
      r_prod <= '0;
      r_pv   <= 1'b0;
      r_acc  <= '0;
      r_tag  <= '0;
    end else if (i_flush) begin
      r_st   <= FREE;
      r_prod <= '0;
      r_pv   <= 1'b0;
      r_acc  <= '0;
    end else begin
      r_pv <= i_beat;
      if (i_beat) r_prod <= i_a * i_b;
      if (i_claim && r_st == FREE) r_acc <= '0;
      else if (r_pv)               r_acc <= r_acc + w_prod_ext;
      case (r_st)
        FREE:  if (i_claim) r_st <= ACC;
        ACC:   if (i_beat && i_last) begin
                 r_st  <= DRAIN;
                 r_tag <= i_tag;
               end
        DRAIN: r_st <= DONE;
        DONE:  if (i_release) r_st <= FREE;
        default: r_st <= FREE;
      endcase
    end
  end

  assign o_busy  = (r_st != FREE);
  assign o_acc   = (r_st == ACC);
  assign o_drain = (r_st == DRAIN);
  assign o_ready = (r_st == DRAIN) || (r_st == DONE);
  // A draining lane still has its final product in flight; fold it in so the
  // result register can load at the same edge the lane becomes DONE.
  assign o_sum   = (r_st == DRAIN) ? r_acc + w_prod_ext : r_acc;
  assign o_tag   = r_tag;
endmodule

module mult_pool_collector #(
  parameter int Nmult = 16,
  parameter int Mmult = 5,
  parameter int W     = 16,
  parameter int ACCW  = 40,
  parameter int TAGW  = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic [Nmult-1:0] claim_vec,
  output logic [Nmult-1:0] mult_Loc_in,
  output logic [Mmult-1:0] free_mult_no,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [Mmult-1:0] op_mult,
  input  logic [W-1:0]     op_a,
  input  logic [W-1:0]     op_b,
  input  logic             op_last,
  input  logic [TAGW-1:0]  op_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACCW-1:0]  res_data,
  output logic [TAGW-1:0]  res_tag,
  output logic [Mmult-1:0] res_mult,
  output logic             err
);
  logic [Nmult-1:0]            w_map, w_acc_vec, w_drain_vec, w_rdy_vec;
  logic [Nmult-1:0]            w_sel, w_beat, w_release, w_claim;
  logic [Nmult-1:0][ACCW-1:0]  w_sum;
  logic [Nmult-1:0][TAGW-1:0]  w_tag;
  logic                        w_hs, w_any, w_claim_err, w_op_err;
  logic [Mmult-1:0]            w_pick, w_free;
  logic [ACCW-1:0]             w_pick_sum;
  logic [TAGW-1:0]             w_pick_tag;
  logic                        r_res_valid, r_err;
  logic [ACCW-1:0]             r_res_data;
  logic [TAGW-1:0]             r_res_tag;
  logic [Mmult-1:0]            r_res_mult;

  assign w_hs    = r_res_valid & res_ready;
  assign w_claim = claim_vec & ~w_map;

  always_comb begin
    w_sel     = '0;
    w_release = '0;
    w_free    = '0;
    for (int i = 0; i < Nmult; i++) begin
      w_sel[i]     = (op_mult == Mmult'(i));
      w_release[i] = w_hs && (r_res_mult == Mmult'(i));
      w_free       = w_free + Mmult'(!w_map[i]);
    end
  end

  assign w_beat      = {Nmult{op_valid}} & w_sel & w_acc_vec;
  assign op_ready    = |(w_sel & w_acc_vec);
  assign w_claim_err = |(claim_vec & w_map);
  // Out-of-range op_mult leaves w_sel empty, so it lands in the error case too.
  assign w_op_err    = op_valid && !(|(w_sel & (w_acc_vec | w_drain_vec)));

  for (genvar g = 0; g < Nmult; g++) begin : g_lane
    mpc_lane #(.W(W), .ACCW(ACCW), .TAGW(TAGW)) u_lane (
      .clk(clk), .rstn(rstn), .i_flush(flush), .i_claim(w_claim[g]),
      .i_beat(w_beat[g]), .i_a(op_a), .i_b(op_b), .i_last(op_last),
      .i_tag(op_tag), .i_release(w_release[g]), .o_busy(w_map[g]),
      .o_acc(w_acc_vec[g]), .o_drain(w_drain_vec[g]), .o_ready(w_rdy_vec[g]),
      .o_sum(w_sum[g]), .o_tag(w_tag[g])
    );
  end

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    w_any      = 1'b0;
    w_pick     = '0;
    w_pick_sum = '0;
    w_pick_tag = '0;
    for (int i = Nmult - 1; i >= 0; i--) begin
      if (w_rdy_vec[i]) begin
        w_any      = 1'b1;
        w_pick     = Mmult'(i);
        w_pick_sum = w_sum[i];
        w_pick_tag = w_tag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_mult  <= '0;
      r_err       <= 1'b0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
    end else begin
      r_err <= r_err | w_claim_err | w_op_err;
      if (w_hs) begin
        r_res_valid <= 1'b0;
      end else if (!r_res_valid && w_any) begin
        r_res_valid <= 1'b1;
        r_res_data  <= w_pick_sum;
        r_res_tag   <= w_pick_tag;
        r_res_mult  <= w_pick;
      end
    end
  end

  assign mult_Loc_in  = w_map;
  assign free_mult_no = w_free;
  assign res_valid    = r_res_valid;
  assign res_data     = r_res_data;
  assign res_tag      = r_res_tag;
  assign res_mult     = r_res_mult;
  assign err          = r_err;
endmodule

// File: tb/tb_mult_pool_collector.sv
// Directed bench for mult_pool_collector: a transaction-level pool model checked
// every cycle, plus literal expectations from hand-worked scenarios.

module tb_mult_pool_collector;
  logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0;
  logic [15:0] claim_vec = '0;
  logic [15:0] mult_Loc_in;
  logic [4:0]  free_mult_no;
  logic        op_valid = 1'b0, op_ready, op_last = 1'b0;
  logic [4:0]  op_mult = '0;
  logic [15:0] op_a = '0, op_b = '0;
  logic [9:0]  op_tag = '0;
  logic        res_valid, res_ready = 1'b0, err;
  logic [39:0] res_data;
  logic [9:0]  res_tag;
  logic [4:0]  res_mult;

  int n_tests = 0, n_fail = 0;

  mult_pool_collector dut (
    .clk(clk), .rstn(rstn), .flush(flush), .claim_vec(claim_vec),
    .mult_Loc_in(mult_Loc_in), .free_mult_no(free_mult_no),
    .op_valid(op_valid), .op_ready(op_ready), .op_mult(op_mult),
    .op_a(op_a), .op_b(op_b), .op_last(op_last), .op_tag(op_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_tag(res_tag), .res_mult(res_mult), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pool model: lanes are claimed/accumulating/finished; a finished lane is
  // offered two cycles after its last beat, one result in flight at a time.
  bit          m_map  [16];
  bit          m_pend [16];
  int          m_done [16];
  logic [39:0] m_sum  [16];
  logic [9:0]  m_tag  [16];
  bit          m_err = 0, m_rv = 0;
  logic [39:0] m_rd = '0;
  logic [9:0]  m_rt = '0;
  int          m_rm = 0, cyc = 0;

  task automatic model_clear_lanes();
    for (int i = 0; i < 16; i++) begin
      m_map[i] = 0; m_pend[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_tag[i] = '0;
    end
    m_rv = 0;
  endtask

  initial begin
    model_clear_lanes();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        model_clear_lanes();
        m_err = 0; m_rd = '0; m_rt = '0; m_rm = 0; cyc = 0;
      end else begin
        if (flush) begin
          model_clear_lanes();
        end else begin
          bit map0 [16];
          int idx;
          for (int i = 0; i < 16; i++) map0[i] = m_map[i];
          if (m_rv) begin
            if (res_ready) begin
              m_map[m_rm] = 0; m_pend[m_rm] = 0; m_rv = 0;
            end
          end else begin
            for (int i = 0; i < 16; i++)
              if (!m_rv && m_pend[i] && m_done[i] <= cyc + 1) begin
                m_rv = 1; m_rd = m_sum[i]; m_rt = m_tag[i]; m_rm = i;
              end
          end
          for (int i = 0; i < 16; i++)
            if (claim_vec[i]) begin
              if (map0[i]) m_err = 1;
              else begin m_map[i] = 1; m_sum[i] = '0; m_pend[i] = 0; end
            end
          if (op_valid) begin
            idx = int'(op_mult);
            if (idx < 16 && map0[idx] && !m_pend[idx]) begin
              m_sum[idx] = m_sum[idx] +
                40'(longint'($signed(op_a)) * longint'($signed(op_b)));
              if (op_last) begin
                m_pend[idx] = 1; m_done[idx] = cyc + 2; m_tag[idx] = op_tag;
              end
            end else if (!(idx < 16 && map0[idx] && m_pend[idx] && m_done[idx] == cyc + 1))
              m_err = 1;
          end
        end
        cyc++;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    begin
      logic [15:0] emap;
      int efree, idx;
      bit erdy;
      efree = 0;
      for (int i = 0; i < 16; i++) begin
        emap[i] = m_map[i];
        if (!m_map[i]) efree++;
      end
      idx  = int'(op_mult);
      erdy = (idx < 16) && m_map[idx] && !m_pend[idx];
      chk("map", longint'(mult_Loc_in), longint'(emap));
      chk("free_mult_no", longint'(free_mult_no), longint'(efree));
      chk("op_ready", longint'(op_ready), longint'(erdy));
      chk("err", longint'(err), longint'(m_err));
      chk("res_valid", longint'(res_valid), longint'(m_rv));
      if (res_valid && m_rv) begin
        chk("res_data", longint'($signed(res_data)), longint'($signed(m_rd)));
        chk("res_tag", longint'(res_tag), longint'(m_rt));
        chk("res_mult", longint'(res_mult), longint'(m_rm));
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic idle();
    op_valid = 0; op_last = 0; claim_vec = '0; flush = 0;
  endtask

  task automatic beat(input int lane, input logic signed [15:0] a,
                      input logic signed [15:0] b, input bit last,
                      input logic [9:0] tag);
    op_valid = 1; op_mult = 5'(lane); op_a = a; op_b = b;
    op_last = last; op_tag = tag;
    tick();
  endtask

  task automatic do_reset();
    rstn = 0; idle(); res_ready = 0; op_mult = '0;
    repeat (2) tick();
    rstn = 1;
  endtask

  task automatic wait_res(input int maxc);
    bit ok;
    ok = 0;
    for (int k = 0; k < maxc && !ok; k++) begin
      @(negedge clk);
      if (res_valid) ok = 1;
    end
    if (!ok) chk("res_valid timeout", 0, 1);
  endtask

  task automatic accept();
    res_ready = 1; tick(); res_ready = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL global timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset map", longint'(mult_Loc_in), 0);
    chk("reset free", longint'(free_mult_no), 16);
    chk("reset res_valid", longint'(res_valid), 0);
    chk("reset err", longint'(err), 0);

    // Three taps on lane 3: 6 - 20 + 7 = -7
    claim_vec = 16'h0008; tick(); idle();
    @(negedge clk);
    chk("t1 free after claim", longint'(free_mult_no), 15);
    beat(3, 2, 3, 0, 0); beat(3, -4, 5, 0, 0); beat(3, 7, 1, 1, 10'h12); idle();
    @(negedge clk);
    chk("t1 res_valid t+1", longint'(res_valid), 0);
    tick();
    @(negedge clk);
    chk("t1 res_valid t+2", longint'(res_valid), 1);
    chk("t1 res_data", longint'($signed(res_data)), -7);
    chk("t1 res_tag", longint'(res_tag), 'h12);
    chk("t1 res_mult", longint'(res_mult), 3);
    accept();
    @(negedge clk);
    chk("t1 free after release", longint'(free_mult_no), 16);

    // Lanes 1 and 6; lane 6 finishes first and is held while ready is low
    claim_vec = 16'h0042; tick(); idle();
    beat(6, 1, 1, 0, 0); beat(6, 2, 2, 1, 10'd6); beat(1, 3, 3, 1, 10'd1); idle();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2 held res_mult", longint'(res_mult), 6);
      tick();
    end
    @(negedge clk);
    chk("t2 lane6 data", longint'($signed(res_data)), 5);
    claim_vec = 16'h0001; res_ready = 1; tick(); res_ready = 0; idle();
    @(negedge clk);
    chk("t2 map after lane6 release", longint'(mult_Loc_in), 'h0003);
    wait_res(5);
    chk("t2 lane1 mult", longint'(res_mult), 1);
    chk("t2 lane1 data", longint'($signed(res_data)), 9);
    accept();
    @(negedge clk);
    chk("t2 map after lane1 release", longint'(mult_Loc_in), 'h0001);

    // Full pool, then claim of a busy lane
    do_reset();
    claim_vec = 16'hFFFF; tick(); idle();
    @(negedge clk);
    chk("t3 map full", longint'(mult_Loc_in), 'hFFFF);
    chk("t3 free zero", longint'(free_mult_no), 0);
    chk("t3 err clean", longint'(err), 0);
    claim_vec = 16'h0001; tick(); idle();
    @(negedge clk);
    chk("t3 busy claim err", longint'(err), 1);

    // Operand to unclaimed lane 9, then to out-of-range lane 20
    do_reset();
    op_valid = 1; op_mult = 5'd9; op_a = 1; op_b = 1;
    @(negedge clk);
    chk("t4 op_ready", longint'(op_ready), 0);
    tick(); idle();
    @(negedge clk);
    chk("t4 err", longint'(err), 1);
    chk("t4 map", longint'(mult_Loc_in), 0);
    do_reset();
    op_valid = 1; op_mult = 5'd20; tick(); idle();
    @(negedge clk);
    chk("t4 range err", longint'(err), 1);

    // Flush mid-accumulation, then a fresh single tap
    do_reset();
    claim_vec = 16'h0004; tick(); idle();
    beat(2, 3, 4, 0, 0); beat(2, 5, 6, 0, 0); idle();
    flush = 1; tick(); flush = 0;
    @(negedge clk);
    chk("t5 map", longint'(mult_Loc_in), 0);
    chk("t5 free", longint'(free_mult_no), 16);
    chk("t5 res_valid", longint'(res_valid), 0);
    claim_vec = 16'h0004; tick(); idle();
    beat(2, -1, -1, 1, 10'd5); idle();
    wait_res(5);
    chk("t5 data", longint'($signed(res_data)), 1);
    accept();

    // 27 maximal positive products
    do_reset();
    claim_vec = 16'h0020; tick(); idle();
    for (int k = 0; k < 27; k++) beat(5, 32767, 32767, k == 26, 10'h3FF);
    idle();
    wait_res(5);
    chk("t6 data", longint'($signed(res_data)), 64'sd28989259803);
    chk("t6 tag", longint'(res_tag), 'h3FF);
    accept();
    repeat (2) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_pool_collector.md
Name: mult_pool_collector

Overview:
- Responder side of the convolution controller's multiplier-allocation interface.
- Owns a pool of Nmult multiply-accumulate lanes and publishes the occupancy map and free count that the controller reads.
- Lanes are claimed by the controller and fed operand pairs, one tap per cycle. Each lane accumulates one output pixel's F*F*K products.
- Completed sums are returned over a valid/ready result port, and each lane is released once its result is accepted.

Parameters:
- Nmult, 16, number of MAC lanes.
- Mmult, 5, width of lane index and free count; must satisfy 2^(Mmult-1) >= Nmult.
- W, 16, signed operand width.
- ACCW, 40, signed accumulator/result width; must be >= 2*W.
- TAGW, 10, output-pixel tag width.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of all lanes.
- claim_vec  in  Nmult  one-cycle claim pulse per lane bit (1 = claim).
- mult_Loc_in  out  Nmult  occupancy map, 0 free / 1 occupied (registered).
- free_mult_no  out  Mmult  count of zero bits in mult_Loc_in.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  selected lane can take an operand.
- op_mult  in  Mmult  target lane index.
- op_a  in  W  image sample, signed.
- op_b  in  W  filter weight, signed.
- op_last  in  1  final tap for this lane's pixel.
- op_tag  in  TAGW  output-pixel tag; sampled on the op_last beat.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  ACCW  accumulated sum, signed.
- res_tag  out  TAGW  tag of the result.
- res_mult  out  Mmult  lane producing the result.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rstn low, asynchronous):
  - Every lane goes to FREE, accumulators and product registers clear.
  - mult_Loc_in=0, free_mult_no=Nmult.
  - res_valid=0, res_data/res_tag/res_mult=0, err=0.
  - Reset mid-accumulation discards all partial sums.
- Per-lane states:
  - FREE -> ACC: claim_vec bit is 1 while the lane is FREE. The accumulator is zeroed and the mult_Loc_in bit is set at the same edge.
  - ACC -> DRAIN: accepted beat with op_last=1.
  - DRAIN -> DONE: one cycle later.
  - DONE -> FREE: the lane's result handshake (res_valid and res_ready) completes.
- Claiming:
  - Claims are checked against the current registered map.
  - A claim bit on a non-FREE lane, including a lane being released that same cycle, is ignored and sets err.
  - A released lane is claimable from the next cycle.
- Operand handshake:
  - op_ready = (op_mult < Nmult) and lane[op_mult] is in ACC.
  - A beat is accepted when op_valid and op_ready are both high.
  - op_valid while op_ready is low sets err only when the target lane is not in ACC or DRAIN. The beat is not consumed.
- Datapath:
  - Edge ending accept cycle t: prod <= op_a*op_b, a full 2W-bit signed product.
  - Edge ending t+1: acc <= acc + sign-extended prod, modulo 2^ACCW.
  - If the beat was last, the lane enters DONE at that same edge, so res_valid can first rise in cycle t+2.
  - A lane accepts at most one beat per cycle. Back-to-back beats to one lane pipeline without stalls.
- Result arbitration:
  - Among DONE lanes, the lowest index wins.
  - Once res_valid is high, res_data, res_tag and res_mult are held stable until the handshake. No re-arbitration while res_ready is low.
  - After a handshake, the next DONE lane is presented in the following cycle at the earliest.
  - res_valid is registered.
- free_mult_no is the popcount of ~mult_Loc_in. It is combinational from the registered map and updates the cycle after a claim or release.
- flush has priority over claims, operands and results:
  - All lanes go to FREE at the edge.
  - Accumulators and pending products clear.
  - res_valid drops, the map clears and free_mult_no=Nmult next cycle.
  - err is unchanged.
- Simultaneous events:
  - An accept and the lane's own result handshake cannot coincide, because a DONE lane is not in ACC.
  - A claim on lane x and a result handshake on lane y (x≠y) in the same cycle are both honoured.
- err:
  - Clears only on reset.
  - Sources: claim of a busy lane, operand to a non-claimed lane, op_mult >= Nmult with op_valid.

Test Plan:
- Reset, then claim lane 3 and send taps (2,3),(−4,5),(7,1 last, tag=0x12) -> res_valid in cycle 2 after last beat, res_data=−7, res_tag=0x12, res_mult=3. free_mult_no goes 16→15, then back to 16 the cycle after the handshake.
- Claim lanes 1 and 6 in one cycle, finish lane 6 first, then lane 1, hold res_ready=0 for 5 cycles -> res_mult=6 held stable until ready. Lane 1 follows. Both map bits clear only after their own handshake.
- Claim all 16 lanes -> mult_Loc_in=0xFFFF, free_mult_no=0. A further claim of lane 0 -> ignored, err=1.
- op_valid to unclaimed lane 9 -> op_ready=0, no state change, err=1.
- Lane 2 mid-accumulation (two taps in), flush pulse -> map=0, free_mult_no=16, res_valid=0. Re-claim lane 2 and send one tap (−1,−1 last) -> res_data=1.
- 27 taps of (32767,32767) on one lane -> res_data=27*1073676289=28989259803, no overflow at ACCW=40.
